// File: rtl/cv32e40x_xif_pkg.sv
// CV32E40X eXtension interface memory-channel types.
// Only the memory request/response/result structs are needed by the vector
// coprocessor's load/store unit, so the package is trimmed to those.
//   x_mem_req_t    : coprocessor -> core memory request
//   x_mem_resp_t   : core -> coprocessor request response
//   x_mem_result_t : core -> coprocessor memory result (read data)
package cv32e40x_xif_pkg;

    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned X_MEM_WIDTH = 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]    id;
        logic [31:0]              addr;
        logic [1:0]               mode;
        logic                     we;
        logic [2:0]               size;
        logic [X_MEM_WIDTH/8-1:0] be;
        logic [1:0]               attr;
        logic [X_MEM_WIDTH-1:0]   wdata;
        logic                     last;
        logic                     spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_MEM_WIDTH-1:0] rdata;
        logic                   err;
        logic                   dbg;
    } x_mem_result_t;

endpackage

// File: rtl/vector_pkg.sv
// Shared definitions for the vector coprocessor: load/store unit state
// encoding, the word-count derivation and the X-interface word size code.
package vector_pkg;

    localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RES,
        LSU_DONE
    } lsu_state_e;

    // Number of 32-bit memory words making up one vector register.
    function automatic int unsigned num_words(input int unsigned vlen);
        return vlen / 32;
    endfunction

endpackage

// File: rtl/vector_lsu.sv
// Vector load/store unit: moves one VLEN-bit vector register to/from memory
// as NUM_WORDS sequential 32-bit transactions on the X-interface memory
// channel, with exactly one transaction outstanding at a time.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_load_i/start_store_i one-cycle start pulses (load wins if both)
//   base_addr_i, store_data_i, id_i  operands sampled on an accepted start
//   load_data_o                assembled load vector
//   done_o                     one-cycle completion pulse
//   xif_mem_*                  X-interface memory request/result channel
//
// state        | meaning
// -------------+-----------------------------------------------------
// LSU_IDLE     | waiting for a start pulse
// LSU_REQ      | presenting word request, held until ready
// LSU_WAIT_RES | request accepted, waiting for its result
// LSU_DONE     | transfer complete, done_o pulses for this cycle
module vector_lsu
    import vector_pkg::*;
#(
    parameter int unsigned VLEN       = 256,
    parameter int unsigned X_ID_WIDTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_load_i,
    input  logic                           start_store_i,
    input  logic [31:0]                    base_addr_i,
    input  logic [VLEN-1:0]                store_data_i,
    output logic [VLEN-1:0]                load_data_o,
    output logic                           done_o,
    input  logic [X_ID_WIDTH-1:0]          id_i,
    output logic                           xif_mem_valid_o,
    input  logic                           xif_mem_ready_i,
    output cv32e40x_xif_pkg::x_mem_req_t   xif_mem_req_o,
    input  cv32e40x_xif_pkg::x_mem_resp_t  xif_mem_resp_i,
    input  logic                           xif_mem_result_valid_i,
    input  cv32e40x_xif_pkg::x_mem_result_t xif_mem_result_i
);

    localparam int unsigned NUM_WORDS = num_words(VLEN);
    localparam int unsigned CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       base_q;
    logic [VLEN-1:0]   wdata_q;
    logic [X_ID_WIDTH-1:0] id_q;
    logic              is_load_q;
    logic [VLEN-1:0]   load_data_q;
    logic [31:0]       word_wdata;
    logic              start;

    // Response and result sideband are deliberately not acted on.
    logic unused_xif;
    assign unused_xif = ^{xif_mem_resp_i, xif_mem_result_i.id,
                          xif_mem_result_i.err, xif_mem_result_i.dbg};

    assign start = start_load_i | start_store_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LSU_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            id_q        <= '0;
            is_load_q   <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == LSU_IDLE && start) begin
                base_q    <= base_addr_i;
                wdata_q   <= store_data_i;
                id_q      <= id_i;
                is_load_q <= start_load_i;
            end
            if (state_q == LSU_WAIT_RES && xif_mem_result_valid_i && is_load_q) begin
                for (int w = 0; w < NUM_WORDS; w++) begin
                    if (cnt_q == CNT_W'(w)) begin
                        load_data_q[32*w +: 32] <= xif_mem_result_i.rdata;
                    end
                end
            end
        end
    end

    always_comb begin
        word_wdata = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (cnt_q == CNT_W'(w)) begin
                word_wdata = wdata_q[32*w +: 32];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        xif_mem_valid_o = 1'b0;
        done_o          = 1'b0;

        xif_mem_req_o       = '0;
        xif_mem_req_o.id    = id_q;
        xif_mem_req_o.addr  = base_q + (32'(cnt_q) << 2);
        xif_mem_req_o.mode  = 2'b11;
        xif_mem_req_o.we    = ~is_load_q;
        xif_mem_req_o.size  = MEM_SIZE_WORD;
        xif_mem_req_o.be    = 4'hF;
        xif_mem_req_o.wdata = word_wdata;
        xif_mem_req_o.last  = (cnt_q == LAST_CNT);

        unique case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                xif_mem_valid_o = 1'b1;
                if (xif_mem_ready_i) begin
                    state_d = LSU_WAIT_RES;
                end
            end
            LSU_WAIT_RES: begin
                if (xif_mem_result_valid_i) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = LSU_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_DONE: begin
                done_o  = 1'b1;
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    assign load_data_o = load_data_q;

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: directed scenarios plus randomized
// transfers, compared against a transaction-level model of the transfer.
module tb_vector_lsu;
    import cv32e40x_xif_pkg::*;

    localparam int VLEN = 256;
    localparam int NW   = VLEN / 32;
    localparam int XID  = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_load_i, start_store_i;
    logic [31:0]     base_addr_i;
    logic [VLEN-1:0] store_data_i;
    logic [VLEN-1:0] load_data_o;
    logic            done_o;
    logic [XID-1:0]  id_i;
    logic            xif_mem_valid_o, xif_mem_ready_i;
    x_mem_req_t      xif_mem_req_o;
    x_mem_resp_t     xif_mem_resp_i;
    logic            xif_mem_result_valid_i;
    x_mem_result_t   xif_mem_result_i;

    always #5 clk_i = ~clk_i;

    vector_lsu #(.VLEN(VLEN), .X_ID_WIDTH(XID)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .start_load_i           (start_load_i),
        .start_store_i          (start_store_i),
        .base_addr_i            (base_addr_i),
        .store_data_i           (store_data_i),
        .load_data_o            (load_data_o),
        .done_o                 (done_o),
        .id_i                   (id_i),
        .xif_mem_valid_o        (xif_mem_valid_o),
        .xif_mem_ready_i        (xif_mem_ready_i),
        .xif_mem_req_o          (xif_mem_req_o),
        .xif_mem_resp_i         (xif_mem_resp_i),
        .xif_mem_result_valid_i (xif_mem_result_valid_i),
        .xif_mem_result_i       (xif_mem_result_i)
    );

    int checks = 0;
    int errors = 0;
    logic [VLEN-1:0] exp_load = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // One whole transfer. stall_word/stall_cycles hold ready low on that
    // word; extra_cyc pulses a stray start mid-transfer; rst_word asserts
    // reset while that word's request is being presented (-1 = never).
    task automatic do_xfer(input bit ld, input bit st, input logic [31:0] base,
                           input logic [VLEN-1:0] sdata, input logic [XID-1:0] id,
                           input bit fixed_rd, input int stall_word, input int stall_cycles,
                           input int extra_cyc, input int rst_word);
        logic [31:0]     rd [NW];
        logic [VLEN-1:0] exp_vec;
        x_mem_req_t      exp_req;
        bit              is_load, pending, rv;
        int              pend_idx, nreq, ndone, done_cyc, stall_left;

        for (int i = 0; i < NW; i++) rd[i] = fixed_rd ? 32'h1111_0000 + 32'(i) : $urandom;
        is_load    = ld;
        exp_vec    = exp_load;
        pending    = 1'b0;
        pend_idx   = 0;
        nreq       = 0;
        ndone      = 0;
        done_cyc   = -1;
        stall_left = stall_cycles;

        start_load_i  = ld;
        start_store_i = st;
        base_addr_i   = base;
        store_data_i  = sdata;
        id_i          = id;
        @(posedge clk_i); #1;
        start_load_i  = 1'b0;
        base_addr_i   = $urandom;
        store_data_i  = rand_vec();
        id_i          = XID'($urandom);

        for (int cyc = 1; cyc <= 150; cyc++) begin
            start_store_i = (cyc == extra_cyc);
            rv = pending;
            pending = 1'b0;
            xif_mem_result_valid_i   = rv;
            xif_mem_result_i.id      = XID'($urandom);
            xif_mem_result_i.rdata   = rv ? rd[pend_idx] : $urandom;
            xif_mem_result_i.err     = 1'($urandom);
            xif_mem_result_i.dbg     = 1'b0;
            xif_mem_resp_i           = x_mem_resp_t'($urandom);
            if (rv && is_load) exp_vec[32*pend_idx +: 32] = rd[pend_idx];

            if (rst_word >= 0 && nreq == rst_word && xif_mem_valid_o) begin
                rst_ni = 1'b0;
                #1;
                check("rst_valid", 256'(xif_mem_valid_o), 256'(0));
                check("rst_done", 256'(done_o), 256'(0));
                check("rst_load", 256'(load_data_o), 256'(0));
                exp_load = '0;
                xif_mem_result_valid_i = 1'b0;
                xif_mem_ready_i = 1'b1;
                start_store_i = 1'b0;
                repeat (3) begin
                    @(posedge clk_i); #1;
                    check("rst_no_req", 256'(xif_mem_valid_o), 256'(0));
                end
                rst_ni = 1'b1;
                @(posedge clk_i); #1;
                check("rst_idle", 256'(xif_mem_valid_o), 256'(0));
                return;
            end

            if (xif_mem_valid_o) begin
                if (nreq >= NW) begin
                    check("extra_req", 256'(nreq), 256'(NW - 1));
                    xif_mem_ready_i = 1'b1;
                end else begin
                    exp_req       = '0;
                    exp_req.id    = id;
                    exp_req.addr  = base + 32'(4 * nreq);
                    exp_req.mode  = 2'b11;
                    exp_req.we    = ~is_load;
                    exp_req.size  = 3'b010;
                    exp_req.be    = 4'hF;
                    exp_req.wdata = sdata[32*nreq +: 32];
                    exp_req.last  = (nreq == NW - 1);
                    check("req", 256'(xif_mem_req_o), 256'(exp_req));
                    if (nreq == stall_word && stall_left > 0) begin
                        xif_mem_ready_i = 1'b0;
                        stall_left--;
                    end else begin
                        xif_mem_ready_i = 1'b1;
                        pending  = 1'b1;
                        pend_idx = nreq;
                        nreq++;
                    end
                end
            end else begin
                xif_mem_ready_i = 1'($urandom);
            end

            if (done_o) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("done_vec", 256'(load_data_o), 256'(exp_vec));
                end
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
            @(posedge clk_i); #1;
        end
        start_store_i = 1'b0;
        xif_mem_result_valid_i = 1'b0;
        check("nreq", 256'(nreq), 256'(NW));
        check("ndone", 256'(ndone), 256'(1));
        check("done_cyc", 256'(done_cyc), 256'(2 * NW + 1 + stall_cycles));
        exp_load = exp_vec;
        check("load_hold", 256'(load_data_o), 256'(exp_load));
    endtask

    initial begin
        logic [VLEN-1:0] sd;
        start_load_i = 0; start_store_i = 0; base_addr_i = '0; store_data_i = '0;
        id_i = '0; xif_mem_ready_i = 0; xif_mem_resp_i = '0;
        xif_mem_result_valid_i = 0; xif_mem_result_i = '0;

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_valid", 256'(xif_mem_valid_o), 256'(0));
        check("reset_done", 256'(done_o), 256'(0));
        check("reset_load", 256'(load_data_o), 256'(0));
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // directed load
        do_xfer(1, 0, 32'h1000, rand_vec(), 4'h3, 1, -1, 0, 0, -1);
        // directed store, load_data_o must be untouched
        for (int i = 0; i < NW; i++) sd[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
        do_xfer(0, 1, 32'h2000, sd, 4'h5, 0, -1, 0, 0, -1);
        // backpressure on word 2
        do_xfer(1, 0, 32'h3000, rand_vec(), 4'h7, 0, 2, 3, 0, -1);
        // both starts together plus a stray start mid-transfer
        do_xfer(1, 1, 32'h4000, rand_vec(), 4'h9, 0, -1, 0, 5, -1);
        // reset during word 4, then a fresh load
        do_xfer(1, 0, 32'h5000, rand_vec(), 4'hA, 0, -1, 0, 0, 4);
        do_xfer(1, 0, 32'h6000, rand_vec(), 4'hB, 0, -1, 0, 0, -1);
        // address wrap
        do_xfer(1, 0, 32'hFFFF_FFF8, rand_vec(), 4'hC, 0, -1, 0, 0, -1);

        for (int n = 0; n < 12; n++) begin
            bit ld;
            ld = 1'($urandom);
            do_xfer(ld, ~ld, $urandom, rand_vec(), XID'($urandom), 0,
                    $urandom_range(0, NW - 1), $urandom_range(0, 4), 0, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
